// File: rtl/mem_block_master.sv
// ---------------------------------------------------------------------------
// mem_block_master
//
// Load/store controller between the pipeline MEM stage and a word-organised
// data memory (2^ADDR_W x 32, registered read data).  Byte and halfword
// accesses at byte addresses become word accesses.  Sub-word stores use a
// read-modify-write cycle.  Loads are sign- or zero-extended.
//
// Ports
//   clk            system clock (memory reads on posedge, writes on negedge)
//   reset          synchronous active-high reset
//   req_valid      request present
//   req_ready      unit idle, request will be accepted on the next posedge
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 reserved
//   req_signed     sign-extend loads
//   req_addr       byte address (ADDR_W+2 bits)
//   req_wdata      store data, right-aligned
//   resp_valid     one-cycle completion pulse
//   resp_err       misaligned / reserved-size request (valid with resp_valid)
//   resp_rdata     extended load data (valid with resp_valid)
//   mem_da         memory word address
//   mem_write_data merged write word (zero outside the write cycle)
//   mem_memread    memory read strobe
//   mem_memwrite   memory write strobe
//   mem_doa        memory read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module mem_block_master #(
   parameter int ADDR_W          = 12,
   parameter bit WORD_STORE_FAST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_da,
   output logic [31:0]       mem_write_data,
   output logic              mem_memread,
   output logic              mem_memwrite,
   input  logic [31:0]       mem_doa
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_DATA = 3'd2,
      S_WR   = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_write;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [ADDR_W+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_wbuf;

   logic                w_misaligned;
   logic [7:0]          w_doa_byte [4];
   logic [7:0]          w_lane_src [4];
   logic [3:0]          w_lane_sel;
   logic [31:0]         w_merged;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load_ext;

   // Request alignment check on the live request fields (used in IDLE only).
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         SZ_HALF: w_misaligned = req_addr[0];
         SZ_WORD: w_misaligned = (req_addr[1:0] != 2'b00);
         SZ_BYTE: w_misaligned = 1'b0;
         default: w_misaligned = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_misaligned) begin
                  w_state_next = S_ERR;
               end else if (req_write && (req_size == SZ_WORD) && WORD_STORE_FAST) begin
                  w_state_next = S_WR;
               end else begin
                  w_state_next = S_RD;
               end
            end
         end
         // A word store in RMW mode still issues the read, but its data is
         // fully overwritten, so it goes straight to the write.
         S_RD:    w_state_next = (r_write && (r_size == SZ_WORD)) ? S_WR : S_DATA;
         S_DATA:  w_state_next = r_write ? S_WR : S_IDLE;
         S_WR:    w_state_next = S_IDLE;
         S_ERR:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (strobes are gated by reset so a reset cycle never writes)
   // -------------------------------------------------------------------------
   always_comb begin
      req_ready      = (r_state == S_IDLE);
      mem_memread    = (r_state == S_RD) && !reset;
      mem_memwrite   = (r_state == S_WR) && !reset;
      mem_write_data = 32'd0;
      if (r_state == S_WR) begin
         mem_write_data = (r_size == SZ_WORD) ? r_wdata : r_wbuf;
      end
   end

   assign mem_da = r_addr[ADDR_W+1:2];

   // -------------------------------------------------------------------------
   // Lane extraction and store merge
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_doa_byte[gi] = mem_doa[8*gi +: 8];

      // Lane gi is overwritten by the store when it falls inside the
      // addressed byte/half/word.
      assign w_lane_sel[gi] = (r_size == SZ_WORD)
                            | ((r_size == SZ_HALF) && (r_addr[1] == ((gi >= 2) ? 1'b1 : 1'b0)))
                            | ((r_size == SZ_BYTE) && (r_addr[1:0] == 2'(gi)));

      // Store data is right-aligned, so it is replicated into every lane.
      assign w_lane_src[gi] = (r_size == SZ_BYTE) ? r_wdata[7:0] :
                              (r_size == SZ_HALF) ? r_wdata[8*(gi%2) +: 8] :
                                                    r_wdata[8*gi +: 8];

      assign w_merged[8*gi +: 8] = w_lane_sel[gi] ? w_lane_src[gi] : w_doa_byte[gi];
   end

   assign w_byte = w_doa_byte[r_addr[1:0]];
   assign w_half = r_addr[1] ? mem_doa[31:16] : mem_doa[15:0];

   always_comb begin
      w_load_ext = mem_doa;
      case (r_size)
         SZ_BYTE: w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
         SZ_HALF: w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load_ext = mem_doa;
      endcase
   end

   // -------------------------------------------------------------------------
   // Request latches, write buffer and response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_wbuf     <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write  <= req_write;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
               end
            end
            S_DATA: begin
               if (r_write) begin
                  r_wbuf <= w_merged;
               end else begin
                  resp_valid <= 1'b1;
                  resp_rdata <= w_load_ext;
               end
            end
            S_WR: begin
               resp_valid <= 1'b1;
               resp_rdata <= 32'd0;
            end
            S_ERR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               resp_rdata <= 32'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_block_master.sv
module tb_mem_block_master;

   localparam int AW = 12;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          s_req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_signed = 1'b0;
   logic [AW+1:0] req_addr = '0;
   logic [31:0]   req_wdata = 32'd0;

   // fast instance
   logic          req_ready, resp_valid, resp_err, mem_memread, mem_memwrite;
   logic [31:0]   resp_rdata, mem_write_data, mem_doa;
   logic [AW-1:0] mem_da;
   // RMW-only instance
   logic          s_req_ready, s_resp_valid, s_resp_err, s_mem_memread, s_mem_memwrite;
   logic [31:0]   s_resp_rdata, s_mem_write_data, s_mem_doa;
   logic [AW-1:0] s_mem_da;

   logic [31:0]   mem0 [0:4095];
   logic [31:0]   mem1 [0:4095];

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            rd_cnt = 0, wr_cnt = 0, last_wr_cyc = -1;
   logic [31:0]   last_wdata = 32'd0;
   int            s_rd_cnt = 0, s_wr_cnt = 0;
   exp_t          sb[$];

   always #5 clk = ~clk;

   mem_block_master #(.ADDR_W(AW), .WORD_STORE_FAST(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_da(mem_da), .mem_write_data(mem_write_data),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_doa(mem_doa)
   );

   mem_block_master #(.ADDR_W(AW), .WORD_STORE_FAST(1'b0)) u_dut_rmw (
      .clk(clk), .reset(reset),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(s_resp_valid), .resp_err(s_resp_err), .resp_rdata(s_resp_rdata),
      .mem_da(s_mem_da), .mem_write_data(s_mem_write_data),
      .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite), .mem_doa(s_mem_doa)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one request on the fast instance; waits (bounded) for req_ready.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [AW+1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input bit push, input bit keep,
                        output int acc);
      exp_t e;
      bit   got;
      got = 1'b0;
      acc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("ready_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      req_write = wr; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      if (!keep) req_valid = 1'b0;
      $display("[TB] accept wr=%0b size=%0d sgn=%0b addr=%h wdata=%08h at cycle %0d",
               wr, sz, sgn, addr, wdata, acc);
      if (push) begin
         e.rdata = exp_rdata; e.err = exp_err; e.due = acc + lat - 1;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("resp_timeout", sb.size(), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int a0, a1, a2, a3, r0, w0, n;
      bit seen;

      fork
         // cycle counter
         forever begin
            @(posedge clk);
            cyc = cyc + 1;
         end
         // memory models: registered read on posedge
         forever begin
            @(posedge clk);
            if (mem_memread) mem_doa <= mem0[mem_da];
            if (s_mem_memread) s_mem_doa <= mem1[s_mem_da];
         end
         // writes on negedge, plus strobe bookkeeping
         forever begin
            @(negedge clk);
            if (mem_memread) rd_cnt = rd_cnt + 1;
            if (mem_memwrite) begin
               mem0[mem_da] = mem_write_data;
               wr_cnt = wr_cnt + 1;
               last_wdata = mem_write_data;
               last_wr_cyc = cyc;
            end
            if (s_mem_memread) s_rd_cnt = s_rd_cnt + 1;
            if (s_mem_memwrite) begin
               mem1[s_mem_da] = s_mem_write_data;
               s_wr_cnt = s_wr_cnt + 1;
            end
         end
         // response monitor / scoreboard
         forever begin
            exp_t e;
            @(negedge clk);
            if (resp_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
               end else begin
                  e = sb.pop_front();
                  $display("[TB] resp cycle %0d err=%0b rdata=%08h (exp err=%0b rdata=%08h cycle %0d)",
                           cyc, resp_err, resp_rdata, e.err, e.rdata, e.due);
                  chk("resp_rdata", resp_rdata, e.rdata);
                  chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                  chk("resp_cycle", cyc, e.due);
               end
            end
         end
      join_none

      mem_doa = 32'd0;
      s_mem_doa = 32'd0;
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = 32'd0;
         mem1[i] = 32'd0;
      end

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_memread", {31'd0, mem_memread}, 32'd0);
      chk("rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mem_da", {20'd0, mem_da}, 32'd0);

      // ---------------- loads ----------------
      mem0[5] = 32'h8899AABB;
      issue(1'b0, 2'b00, 1'b1, 14'h17, 32'd0, 32'hFFFFFF88, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b0, 2'b00, 1'b0, 14'h14, 32'd0, 32'h000000BB, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b0, 2'b00, 1'b1, 14'h15, 32'd0, 32'hFFFFFFAA, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b0, 2'b01, 1'b1, 14'h14, 32'd0, 32'hFFFFAABB, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b0, 2'b01, 1'b0, 14'h16, 32'd0, 32'h00008899, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b0, 2'b10, 1'b1, 14'h14, 32'd0, 32'h8899AABB, 1'b0, 3, 1, 0, a0); drain();

      // ---------------- sub-word stores (RMW) ----------------
      r0 = rd_cnt; w0 = wr_cnt;
      issue(1'b1, 2'b01, 1'b0, 14'h16, 32'h00001234, 32'd0, 1'b0, 4, 1, 0, a0); drain();
      chk("half_st_reads", rd_cnt - r0, 32'd1);
      chk("half_st_writes", wr_cnt - w0, 32'd1);
      chk("half_st_wdata", last_wdata, 32'h1234AABB);
      issue(1'b0, 2'b10, 1'b0, 14'h14, 32'd0, 32'h1234AABB, 1'b0, 3, 1, 0, a0); drain();
      issue(1'b1, 2'b00, 1'b0, 14'h15, 32'hFFFFFFCD, 32'd0, 1'b0, 4, 1, 0, a0); drain();
      chk("byte_st_mem", mem0[5], 32'h1234CDBB);

      // ---------------- fast word store ----------------
      r0 = rd_cnt; w0 = wr_cnt;
      issue(1'b1, 2'b10, 1'b0, 14'h20, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 0, a0); drain();
      chk("wst_reads", rd_cnt - r0, 32'd0);
      chk("wst_writes", wr_cnt - w0, 32'd1);
      chk("wst_write_cycle", last_wr_cyc, a0);
      chk("wst_mem", mem0[8], 32'hDEADBEEF);

      // ---------------- misaligned / reserved ----------------
      r0 = rd_cnt; w0 = wr_cnt;
      issue(1'b0, 2'b10, 1'b0, 14'h22, 32'd0, 32'd0, 1'b1, 2, 1, 0, a0); drain();
      issue(1'b0, 2'b01, 1'b1, 14'h15, 32'd0, 32'd0, 1'b1, 2, 1, 0, a0); drain();
      issue(1'b0, 2'b11, 1'b0, 14'h14, 32'd0, 32'd0, 1'b1, 2, 1, 0, a0); drain();
      issue(1'b1, 2'b01, 1'b0, 14'h17, 32'hFFFF5555, 32'd0, 1'b1, 2, 1, 0, a0); drain();
      chk("err_reads", rd_cnt - r0, 32'd0);
      chk("err_writes", wr_cnt - w0, 32'd0);
      chk("err_mem_unchanged", mem0[5], 32'h1234CDBB);

      // ---------------- back-to-back loads ----------------
      mem0[16] = 32'h01020384;
      mem0[17] = 32'h7F00FF00;
      issue(1'b0, 2'b10, 1'b0, 14'h40, 32'd0, 32'h01020384, 1'b0, 3, 1, 1, a0);
      issue(1'b0, 2'b00, 1'b1, 14'h40, 32'd0, 32'hFFFFFF84, 1'b0, 3, 1, 1, a1);
      issue(1'b0, 2'b01, 1'b0, 14'h46, 32'd0, 32'h00007F00, 1'b0, 3, 1, 1, a2);
      issue(1'b0, 2'b01, 1'b1, 14'h44, 32'd0, 32'hFFFFFF00, 1'b0, 3, 1, 0, a3);
      drain();
      chk("b2b_spacing_1", a1 - a0, 32'd3);
      chk("b2b_spacing_2", a2 - a1, 32'd3);
      chk("b2b_spacing_3", a3 - a2, 32'd3);

      // ---------------- RMW-only instance: word store ----------------
      @(negedge clk);
      req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 14'h20; req_wdata = 32'hDEADBEEF; s_req_valid = 1'b1;
      @(posedge clk);
      #1;
      s_req_valid = 1'b0;
      req_write = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (s_resp_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      $display("[TB] rmw word store resp after %0d cycles err=%0b rdata=%08h", n, s_resp_err, s_resp_rdata);
      chk("rmw_resp_seen", {31'd0, seen}, 32'd1);
      chk("rmw_latency", n, 32'd3);
      chk("rmw_resp_err", {31'd0, s_resp_err}, 32'd0);
      chk("rmw_resp_rdata", s_resp_rdata, 32'd0);
      chk("rmw_reads", s_rd_cnt, 32'd1);
      chk("rmw_writes", s_wr_cnt, 32'd1);
      chk("rmw_mem", mem1[8], 32'hDEADBEEF);

      // ---------------- reset during WR of a byte store ----------------
      mem0[12] = 32'h11223344;
      w0 = wr_cnt;
      issue(1'b1, 2'b00, 1'b0, 14'h30, 32'h000000AA, 32'd0, 1'b0, 4, 0, 0, a0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rstwr_memwrite", {31'd0, mem_memwrite}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rstwr_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      chk("rstwr_resp_valid", {31'd0, resp_valid}, 32'd0);
      repeat (4) @(negedge clk);
      chk("rstwr_mem", mem0[12], 32'h11223344);
      chk("rstwr_writes", wr_cnt - w0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_block_master.md
Name: mem_block_master

Overview:
- Initiator-side load/store controller that drives the 4K x 32 data memory block (12-bit word address, memread/memwrite strobes, registered read data) on behalf of the pipeline MEM stage.
- Converts byte/halfword/word loads and stores at byte addresses into word accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the MEM-stage request/response handshake and the memory block ports.

Parameters:
- ADDR_W, 12, memory word-address width; byte address width is ADDR_W+2.
- WORD_STORE_FAST, 1, 1 = word stores skip the read phase; 0 = every store performs RMW.

Ports:
- clk  in  1  system clock; memory reads on posedge, writes on negedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high when the unit can accept a request (state IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  load sign-extend enable.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned or reserved-size request; valid with resp_valid.
- resp_rdata  out  32  extended load data; valid with resp_valid.
- mem_da  out  ADDR_W  word address to memory = latched addr[ADDR_W+1:2].
- mem_write_data  out  32  merged write word.
- mem_memread  out  1  read strobe.
- mem_memwrite  out  1  write strobe.
- mem_doa  in  32  memory read data; valid in the cycle after mem_memread is sampled.

Behaviour:
- Reset: state IDLE; resp_valid=0; resp_err=0; resp_rdata=0; internal address/data latches=0.
- mem_memread and mem_memwrite are combinationally forced to 0 whenever reset=1, so no write occurs in a reset cycle. Reset mid-operation aborts the access with no response.
- Byte order is little-endian: byte lane = addr[1:0], lane 0 = bits [7:0]; half lane = addr[1], lane 0 = bits [15:0].
- Accept: in IDLE with req_valid=1 at posedge, latch all req_* fields. req_ready=0 in every non-IDLE state.
- Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Go to ERR; no strobe is ever asserted.
  - resp_valid=1, resp_err=1, resp_rdata=0 in the following cycle.
- FSM states: IDLE, RD, DATA, WR, ERR.
  - IDLE -> RD on a load or sub-word store; -> WR on a word store when WORD_STORE_FAST=1; -> ERR on misaligned.
  - RD: mem_memread=1. -> DATA.
  - DATA: mem_doa valid.
    - Load: extract lane, extend (signed: replicate top bit of lane; unsigned: zero), register into resp_rdata. -> IDLE.
    - Store: merge req_wdata low byte/half into the selected lane of mem_doa, register into the write buffer. -> WR.
  - WR: mem_memwrite=1; mem_write_data = write buffer (word store: req_wdata). -> IDLE.
  - ERR: -> IDLE.
- resp_valid is a registered pulse, high for exactly one cycle, in the cycle after DATA (load), WR or ERR. That cycle is IDLE, so a new request may be accepted in it (back-to-back).
- Latency (accept edge to resp_valid cycle):
  - load 3;
  - word store 2 (fast) / 3 (RMW);
  - sub-word store 4;
  - error 2.
- Stores return resp_rdata=0 and resp_err=0.
- mem_da is held stable through RD/DATA/WR; mem_write_data is 0 outside WR.
- mem_da carries the latched word address in every state; there is no wrap-around (addresses are modulo 2^ADDR_W by truncation).

Test Plan:
- After reset, pre-load word 5 = 0x8899AABB. Load byte signed at addr 0x17 -> resp_rdata=0xFFFFFF88 three cycles after accept. Unsigned at 0x14 -> 0x000000BB.
- Store half 0x1234 at addr 0x16 onto 0x8899AABB -> mem_memread one cycle, then mem_memwrite with data 0x1234AABB. Subsequent word load of addr 0x14 returns 0x1234AABB.
- Word store 0xDEADBEEF at addr 0x20 (WORD_STORE_FAST=1) -> no mem_memread, mem_memwrite in cycle 1, resp_valid in cycle 2. Repeat with WORD_STORE_FAST=0 -> RMW path, resp_valid in cycle 3.
- Word load at 0x22, half at 0x15, size 11 -> each yields resp_err=1, resp_rdata=0 two cycles after accept; strobes never asserted; memory unchanged.
- Back-to-back: hold req_valid high with 4 loads -> each accepted in its resp_valid cycle, one response per 3 cycles, data in order.
- Assert reset during the WR cycle of a byte store -> mem_memwrite=0 that cycle, target word unchanged, no resp_valid, req_ready=1 the next cycle.
